// File: rtl/ptw_arb_pkg.sv
// rtl/ptw_arb_pkg.sv - shared state, requester and owner definitions for the PTW memory arbiter
package ptw_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t DRAIN = 2'd3;

  typedef logic owner_t;

  localparam owner_t REQ_I = 1'b0;
  localparam owner_t REQ_D = 1'b1;

  function automatic owner_t grant_owner(input logic [1:0] grant);
    return grant[REQ_D] ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a last-grant register
module rr_arb2
  import ptw_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  owner_t last_grant;

  // A lone requester always wins; a tie goes to whoever was not granted last.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant <= REQ_D;
    end else if (advance && (req != 2'b00)) begin
      last_grant <= grant_owner(grant);
    end
  end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// rtl/ptw_mem_arbiter.sv - shares one AXI read channel between the ITLB and DTLB page-table walkers
module ptw_mem_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  I_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  input  logic                  I_FLUSH,
  output logic                  I_DATA_VALID,
  output logic [DATA_WIDTH-1:0] I_DATA,
  output logic                  I_ERR,
  input  logic                  D_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic                  D_FLUSH,
  output logic                  D_DATA_VALID,
  output logic [DATA_WIDTH-1:0] D_DATA,
  output logic                  D_ERR,
  output logic                  M_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] M_ADDR,
  input  logic                  M_ADDR_READY,
  input  logic                  M_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] M_DATA,
  input  logic                  M_ERR,
  output logic                  BUSY
);

  state_t                state;
  owner_t                owner;
  logic                  pending_i;
  logic                  pending_d;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  discard;

  logic [1:0] req;
  logic [1:0] grant;
  logic       advance;
  logic       launch;
  logic       flush_owner;
  logic       owns_i;
  logic       owns_d;
  logic       cap_i;
  logic       cap_d;
  logic       rsp_take;
  logic       timeout_hit;
  logic       forward;

  assign flush_owner = (owner == REQ_I) ? I_FLUSH : D_FLUSH;

  // A walker still owns the read until its data arrives, unless it flushed it away.
  assign owns_i = (owner == REQ_I) && !discard &&
                  ((state == ISSUE) || ((state == WAIT) && !M_DATA_VALID));
  assign owns_d = (owner == REQ_D) && !discard &&
                  ((state == ISSUE) || ((state == WAIT) && !M_DATA_VALID));

  assign cap_i = I_ADDR_VALID && (I_FLUSH || (!pending_i && !owns_i));
  assign cap_d = D_ADDR_VALID && (D_FLUSH || (!pending_d && !owns_d));

  assign req         = {pending_d && !D_FLUSH, pending_i && !I_FLUSH};
  assign rsp_take    = (state == WAIT) && M_DATA_VALID;
  assign timeout_hit = (state == WAIT) && !M_DATA_VALID &&
                       (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign advance     = (state == IDLE) || rsp_take;
  assign launch      = advance && (req != 2'b00);
  assign forward     = !discard && !flush_owner;

  assign M_ADDR_VALID = (state == ISSUE);
  assign BUSY         = (state != IDLE) || pending_i || pending_d;

  rr_arb2 u_rr_arb2 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_i <= 1'b0;
      pending_d <= 1'b0;
      addr_i    <= '0;
      addr_d    <= '0;
    end else begin
      pending_i <= (pending_i && !I_FLUSH && !(launch && grant[REQ_I])) || cap_i;
      pending_d <= (pending_d && !D_FLUSH && !(launch && grant[REQ_D])) || cap_d;
      if (cap_i) begin
        addr_i <= I_ADDR;
      end
      if (cap_d) begin
        addr_d <= D_ADDR;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      owner   <= REQ_I;
      M_ADDR  <= '0;
      cnt     <= '0;
      discard <= 1'b0;
    end else if (launch) begin
      // A returning response frees the channel in the same cycle the next walk is granted.
      state   <= ISSUE;
      owner   <= grant_owner(grant);
      M_ADDR  <= grant[REQ_I] ? addr_i : addr_d;
      discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        ISSUE: begin
          if (flush_owner) begin
            discard <= 1'b1;
          end
          if (M_ADDR_READY) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (M_DATA_VALID) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (timeout_hit) begin
            state   <= DRAIN;
            discard <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (flush_owner) begin
              discard <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (M_DATA_VALID) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      I_DATA_VALID <= 1'b0;
      I_DATA       <= '0;
      I_ERR        <= 1'b0;
      D_DATA_VALID <= 1'b0;
      D_DATA       <= '0;
      D_ERR        <= 1'b0;
    end else begin
      I_DATA_VALID <= 1'b0;
      I_DATA       <= '0;
      I_ERR        <= 1'b0;
      D_DATA_VALID <= 1'b0;
      D_DATA       <= '0;
      D_ERR        <= 1'b0;
      if (rsp_take && forward) begin
        if (owner == REQ_I) begin
          I_DATA_VALID <= 1'b1;
          I_DATA       <= M_DATA;
          I_ERR        <= M_ERR;
        end else begin
          D_DATA_VALID <= 1'b1;
          D_DATA       <= M_DATA;
          D_ERR        <= M_ERR;
        end
      end else if (timeout_hit && forward) begin
        // The late read is still owed by the master; DRAIN swallows it.
        if (owner == REQ_I) begin
          I_DATA_VALID <= 1'b1;
          I_ERR        <= 1'b1;
        end else begin
          D_DATA_VALID <= 1'b1;
          D_ERR        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb/tb_ptw_mem_arbiter.sv - scoreboard bench for the PTW memory arbiter
module tb_ptw_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          I_ADDR_VALID, I_FLUSH, I_DATA_VALID, I_ERR;
  logic [AW-1:0] I_ADDR;
  logic [DW-1:0] I_DATA;
  logic          D_ADDR_VALID, D_FLUSH, D_DATA_VALID, D_ERR;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_DATA;
  logic          M_ADDR_VALID, M_ADDR_READY, M_DATA_VALID, M_ERR, BUSY;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DATA;

  ptw_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (11)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .I_ADDR_VALID (I_ADDR_VALID),
    .I_ADDR       (I_ADDR),
    .I_FLUSH      (I_FLUSH),
    .I_DATA_VALID (I_DATA_VALID),
    .I_DATA       (I_DATA),
    .I_ERR        (I_ERR),
    .D_ADDR_VALID (D_ADDR_VALID),
    .D_ADDR       (D_ADDR),
    .D_FLUSH      (D_FLUSH),
    .D_DATA_VALID (D_DATA_VALID),
    .D_DATA       (D_DATA),
    .D_ERR        (D_ERR),
    .M_ADDR_VALID (M_ADDR_VALID),
    .M_ADDR       (M_ADDR),
    .M_ADDR_READY (M_ADDR_READY),
    .M_DATA_VALID (M_DATA_VALID),
    .M_DATA       (M_DATA),
    .M_ERR        (M_ERR),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } rsp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  typedef struct {
    logic          iv;
    logic [AW-1:0] ia;
    logic [DW-1:0] idat;
    logic          ierr;
    logic          dv;
    logic [AW-1:0] da;
    logic [DW-1:0] ddat;
    logic          derr;
    int            lat;
    int            rdy_dly;
    logic          i_first;
  } vec_t;

  rsp_t          rsp_q[$];
  rsp_t          cur;
  exp_t          i_exp_q[$];
  exp_t          d_exp_q[$];
  logic [AW-1:0] m_exp_q[$];
  vec_t          vt[8];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  int mav_rise_cyc = 0;
  int mav_hi_cnt = 0;
  int i_dv_cyc = 0;
  int d_dv_cyc = 0;

  logic          prev_mav;
  logic          prev_rdy;
  logic [AW-1:0] prev_addr;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_plan(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e, input int lat);
    rsp_t r;
    r.data = d;
    r.err  = e;
    r.lat  = lat;
    m_exp_q.push_back(a);
    rsp_q.push_back(r);
  endtask

  task automatic push_walk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e,
                           input int lat, input logic to_i);
    exp_t x;
    x.data = d;
    x.err  = e;
    push_plan(a, d, e, lat);
    if (to_i) i_exp_q.push_back(x);
    else      d_exp_q.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((BUSY || rsp_cnt != 0 || rsp_q.size() != 0 || m_exp_q.size() != 0 ||
            i_exp_q.size() != 0 || d_exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_settle: busy=%0b with %0d/%0d/%0d expectations left after %0d cycles, required idle",
               name, BUSY, m_exp_q.size(), i_exp_q.size(), d_exp_q.size(), n);
      m_exp_q.delete();
      i_exp_q.delete();
      d_exp_q.delete();
      rsp_q.delete();
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] idat,
                              input logic ierr, input logic dv, input logic [AW-1:0] da,
                              input logic [DW-1:0] ddat, input logic derr, input int lat,
                              input int rdy_dly, input logic i_first);
    vec_t v;
    v.iv = iv; v.ia = ia; v.idat = idat; v.ierr = ierr;
    v.dv = dv; v.da = da; v.ddat = ddat; v.derr = derr;
    v.lat = lat; v.rdy_dly = rdy_dly; v.i_first = i_first;
    return v;
  endfunction

  initial begin : slave
    M_DATA_VALID = 1'b0;
    M_DATA       = '0;
    M_ERR        = 1'b0;
    forever begin
      @(negedge CLK);
      M_DATA_VALID = 1'b0;
      M_DATA       = '0;
      M_ERR        = 1'b0;
      if (!RST_N) begin
        rsp_cnt = 0;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          M_DATA_VALID = 1'b1;
          M_DATA       = cur.data;
          M_ERR        = cur.err;
        end
      end else if (M_ADDR_VALID && M_ADDR_READY && rsp_q.size() > 0) begin
        cur     = rsp_q.pop_front();
        rsp_cnt = cur.lat;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    prev_mav  = 1'b0;
    prev_rdy  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_mav = 1'b0;
      end else begin
        if (I_DATA_VALID) begin
          i_dv_cyc = cyc;
          if (i_exp_q.size() == 0) chk("i_unexpected_valid", 64'(I_DATA_VALID), 64'd0);
          else begin
            e = i_exp_q.pop_front();
            chk("i_data", I_DATA, e.data);
            chk("i_err", 64'(I_ERR), 64'(e.err));
          end
        end else if (I_DATA !== '0 || I_ERR !== 1'b0) begin
          chk("i_idle_outputs", I_DATA | 64'(I_ERR), 64'd0);
        end
        if (D_DATA_VALID) begin
          d_dv_cyc = cyc;
          if (d_exp_q.size() == 0) chk("d_unexpected_valid", 64'(D_DATA_VALID), 64'd0);
          else begin
            e = d_exp_q.pop_front();
            chk("d_data", D_DATA, e.data);
            chk("d_err", 64'(D_ERR), 64'(e.err));
          end
        end else if (D_DATA !== '0 || D_ERR !== 1'b0) begin
          chk("d_idle_outputs", D_DATA | 64'(D_ERR), 64'd0);
        end
        if (M_ADDR_VALID && !prev_mav) mav_rise_cyc = cyc;
        if (M_ADDR_VALID) mav_hi_cnt++;
        if (prev_mav && !prev_rdy) begin
          chk("m_valid_held", 64'(M_ADDR_VALID), 64'd1);
          chk("m_addr_held", M_ADDR, prev_addr);
        end
        if (M_ADDR_VALID && M_ADDR_READY) begin
          if (m_exp_q.size() == 0) chk("m_unexpected_issue", 64'(M_ADDR_VALID), 64'd0);
          else chk("m_addr", M_ADDR, m_exp_q.pop_front());
        end
        prev_mav  = M_ADDR_VALID;
        prev_rdy  = M_ADDR_READY;
        prev_addr = M_ADDR;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t v;
    int   t0;

    I_ADDR_VALID = 1'b0; I_ADDR = '0; I_FLUSH = 1'b0;
    D_ADDR_VALID = 1'b0; D_ADDR = '0; D_FLUSH = 1'b0;
    M_ADDR_READY = 1'b1;

    repeat (3) step();
    chk("reset_mav", 64'(M_ADDR_VALID), 64'd0);
    chk("reset_maddr", M_ADDR, 64'd0);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_i_dv", 64'(I_DATA_VALID), 64'd0);
    chk("reset_d_dv", 64'(D_DATA_VALID), 64'd0);
    RST_N = 1'b1;
    step();

    vt[0] = mk(1, 64'h1000, 64'h1111_00C1, 0, 1, 64'h2000, 64'h2222_00C2, 0, 3, 0, 1);
    vt[1] = mk(1, 64'h3000, 64'h3333_00C3, 0, 1, 64'h4000, 64'h4444_00C4, 0, 2, 0, 1);
    vt[2] = mk(1, 64'h5000, 64'h5555_00C5, 0, 0, 64'h0,    64'h0,         0, 1, 0, 1);
    vt[3] = mk(1, 64'h6000, 64'h6666_00C6, 0, 1, 64'h7000, 64'h7777_00C7, 0, 3, 0, 0);
    vt[4] = mk(0, 64'h0,    64'h0,         0, 1, 64'h8000, 64'hDEAD_BEEF, 1, 2, 0, 0);
    vt[5] = mk(1, 64'h9000, 64'h9999_00C9, 0, 0, 64'h0,    64'h0,         0, 3, 4, 1);
    vt[6] = mk(1, 64'hB000, 64'hBBBB_00CB, 1, 1, 64'hC000, 64'hCCCC_00CC, 0, 2, 2, 0);
    vt[7] = mk(0, 64'h0,    64'h0,         0, 1, 64'hA000, 64'hAAAA_00CA, 0, 1, 0, 0);

    for (int k = 0; k < 8; k++) begin
      v = vt[k];
      if (v.i_first) begin
        if (v.iv) push_walk(v.ia, v.idat, v.ierr, v.lat, 1'b1);
        if (v.dv) push_walk(v.da, v.ddat, v.derr, v.lat, 1'b0);
      end else begin
        if (v.dv) push_walk(v.da, v.ddat, v.derr, v.lat, 1'b0);
        if (v.iv) push_walk(v.ia, v.idat, v.ierr, v.lat, 1'b1);
      end
      I_ADDR_VALID = v.iv; I_ADDR = v.ia;
      D_ADDR_VALID = v.dv; D_ADDR = v.da;
      M_ADDR_READY = (v.rdy_dly == 0);
      step();
      I_ADDR_VALID = 1'b0;
      D_ADDR_VALID = 1'b0;
      if (v.rdy_dly > 0) begin
        repeat (v.rdy_dly + 1) step();
      end
      M_ADDR_READY = 1'b1;
      wait_idle("vec");
    end

    // single ITLB walk with exact cycle positions
    t0 = cyc;
    mav_hi_cnt = 0;
    push_walk(64'h8000_1000, 64'h2000_00CF, 1'b0, 3, 1'b1);
    I_ADDR_VALID = 1'b1; I_ADDR = 64'h8000_1000;
    step();
    I_ADDR_VALID = 1'b0;
    wait_idle("single");
    chk("single_mav_cycle", 64'(mav_rise_cyc - t0), 64'd2);
    chk("single_mav_len", 64'(mav_hi_cnt), 64'd1);
    chk("single_i_dv_cycle", 64'(i_dv_cyc - t0), 64'd6);

    // DTLB flushed in WAIT; queued ITLB walk takes over as the data returns
    t0 = cyc;
    push_plan(64'hD000, 64'hBAD0_BAD0, 1'b0, 4);
    push_walk(64'h1_C000, 64'h0C0C_00CF, 1'b0, 2, 1'b1);
    D_ADDR_VALID = 1'b1; D_ADDR = 64'hD000;
    step();
    D_ADDR_VALID = 1'b0;
    I_ADDR_VALID = 1'b1; I_ADDR = 64'h1_C000;
    step();
    I_ADDR_VALID = 1'b0;
    step();
    D_FLUSH = 1'b1;
    step();
    D_FLUSH = 1'b0;
    wait_idle("flush_wait");
    chk("flush_wait_i_issue_cycle", 64'(mav_rise_cyc - t0), 64'd7);

    // flush plus new request coinciding with the old walk's data
    t0 = cyc;
    push_plan(64'hE000, 64'hBAD1_BAD1, 1'b0, 3);
    push_walk(64'hF000, 64'h0F0F_00CF, 1'b0, 2, 1'b1);
    I_ADDR_VALID = 1'b1; I_ADDR = 64'hE000;
    step();
    I_ADDR_VALID = 1'b0;
    repeat (4) step();
    I_FLUSH = 1'b1;
    I_ADDR_VALID = 1'b1; I_ADDR = 64'hF000;
    step();
    I_FLUSH = 1'b0;
    I_ADDR_VALID = 1'b0;
    wait_idle("flush_data");
    chk("flush_data_reissue_cycle", 64'(mav_rise_cyc - t0), 64'd7);

    // timeout: error after eight WAIT cycles, late data swallowed in DRAIN
    t0 = cyc;
    begin
      exp_t x;
      x.data = '0;
      x.err  = 1'b1;
      push_plan(64'h7_7000, 64'hBAD2_BAD2, 1'b0, 12);
      i_exp_q.push_back(x);
    end
    I_ADDR_VALID = 1'b1; I_ADDR = 64'h7_7000;
    step();
    I_ADDR_VALID = 1'b0;
    wait_idle("timeout");
    chk("timeout_err_cycle", 64'(i_dv_cyc - t0), 64'd11);

    // asynchronous reset while the walk sits in ISSUE
    M_ADDR_READY = 1'b0;
    I_ADDR_VALID = 1'b1; I_ADDR = 64'h6_6000;
    step();
    I_ADDR_VALID = 1'b0;
    step();
    chk("rst_pre_mav", 64'(M_ADDR_VALID), 64'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_mav", 64'(M_ADDR_VALID), 64'd0);
    chk("rst_maddr", M_ADDR, 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_i_dv", 64'(I_DATA_VALID), 64'd0);
    chk("rst_d_dv", 64'(D_DATA_VALID), 64'd0);
    m_exp_q.delete();
    rsp_q.delete();
    step();
    step();
    RST_N = 1'b1;
    M_ADDR_READY = 1'b1;
    step();
    push_walk(64'h1_1000, 64'h1_1100_00CF, 1'b0, 2, 1'b1);
    push_walk(64'h1_2000, 64'h1_2200_00CF, 1'b0, 2, 1'b0);
    I_ADDR_VALID = 1'b1; I_ADDR = 64'h1_1000;
    D_ADDR_VALID = 1'b1; D_ADDR = 64'h1_2000;
    step();
    I_ADDR_VALID = 1'b0;
    D_ADDR_VALID = 1'b0;
    wait_idle("after_reset");
    chk("final_busy", 64'(BUSY), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
